// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider producing {remainder, quotient} for HI/LO.
// Optional: define DIV_FAST_ZERO_EN to finish a zero dividend in one cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CW-1:0]      r_counter;
  logic [2*WIDTH-1:0] r_work;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_neg_dividend;
  logic               r_neg_divisor;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;

  logic               w_done;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic [WIDTH:0]     w_partial;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_step;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_fixed;

  assign w_done = (r_counter == CW'(WIDTH));
  assign w_abs1 = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign w_abs2 = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

  // One restoring step: the upper half shifted left by one, then a trial subtract.
  assign w_partial = r_work[2*WIDTH-1:WIDTH-1];
  assign w_trial   = w_partial - {1'b0, r_divisor};
  assign w_step    = {w_trial[WIDTH] ? w_partial[WIDTH-1:0] : w_trial[WIDTH-1:0],
                      r_work[WIDTH-2:0], ~w_trial[WIDTH]};

  assign w_quot  = r_work[WIDTH-1:0];
  assign w_rem   = r_work[2*WIDTH-1:WIDTH];
  assign w_fixed = {r_neg_dividend ? -w_rem : w_rem,
                    (r_neg_dividend ^ r_neg_divisor) ? -w_quot : w_quot};

  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    if (annul) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (opdata2 == '0) begin
              w_state_next = S_DIVZERO;
`ifdef DIV_FAST_ZERO_EN
            end else if (opdata1 == '0) begin
              w_state_next = S_END;
`endif
            end else begin
              w_state_next = S_ON;
            end
          end
        end
        S_DIVZERO: w_state_next = S_END;
        S_ON:      if (w_done) w_state_next = S_END;
        S_END:     if (!start) w_state_next = S_IDLE;
        default:   w_state_next = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_counter <= '0;
      r_result  <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_ready <= (w_state_next == S_END);
      if (!annul) begin
        case (r_state)
          S_IDLE: begin
            r_counter <= '0;
            if (w_state_next == S_END) r_result <= '0;
          end
          S_DIVZERO: r_result <= '0;
          S_ON: begin
            if (w_done) r_result  <= w_fixed;
            else        r_counter <= r_counter + CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the datapath needs no reset; it is always loaded at launch before it is read.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start && !annul) begin
      r_work         <= {{WIDTH{1'b0}}, w_abs1};
      r_divisor      <= w_abs2;
      r_neg_dividend <= signed_div & opdata1[WIDTH-1];
      r_neg_divisor  <= signed_div & opdata2[WIDTH-1];
    end else if (r_state == S_ON && !w_done) begin
      r_work <= w_step;
    end
  end

  assign result = r_result;
  assign ready  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random divides
// compared against a plain-arithmetic reference model.
module tb_div_unit;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] last_exp;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .result     (result),
    .ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    if (b == 32'h0) return 64'h0;
    if (!sd) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  function automatic int ref_latency(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return 1;
`ifdef DIV_FAST_ZERO_EN
    if (a == 32'h0) return 1;
`else
    if (a == 32'h0) return 33;
`endif
    return 33;
  endfunction

  // Launch one divide, measure latency, check hold-while-start and release.
  task automatic run_div(input logic sd, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp;
    int want_lat;
    int lat;
    exp      = ref_div(sd, a, b);
    want_lat = ref_latency(a, b);
    signed_div = sd;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    @(posedge clk); #1;
    opdata1    = $urandom;
    opdata2    = $urandom;
    signed_div = 1'($urandom);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ready) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(want_lat));
    check({tag, "_result"}, result, exp);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check({tag, "_hold_ready"}, 64'(ready), 64'(1));
      check({tag, "_hold_result"}, result, exp);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_release_ready"}, 64'(ready), 64'(0));
    check({tag, "_release_result"}, result, exp);
    last_exp = exp;
  endtask

  task automatic watch_no_ready(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      seen = seen | ready;
    end
    check(tag, 64'(seen), 64'(0));
  endtask

  initial begin
    resetn     = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    annul      = 1'b0;
    last_exp   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready), 64'(0));
    check("reset_result", result, 64'h0);
    resetn = 1'b1;
    @(posedge clk); #1;

    run_div(1'b0, 32'd100,        32'd7,        "u_100_7");
    run_div(1'b1, 32'hFFFF_FFF9,  32'h0000_0002, "s_m7_2");
    run_div(1'b1, 32'h0000_0007,  32'hFFFF_FFFE, "s_7_m2");
    run_div(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, "s_min_m1");
    run_div(1'b0, 32'hFFFF_FFFF,  32'h0000_0001, "u_max_1");
    run_div(1'b0, 32'd12345,      32'd0,         "u_div0");
    run_div(1'b1, 32'hDEAD_BEEF,  32'd0,         "s_div0");
    run_div(1'b0, 32'd0,          32'd5,         "u_zero_dividend");
    run_div(1'b1, 32'd0,          32'd5,         "s_zero_dividend");

    // Annul in the middle of a divide, then a normal divide.
    signed_div = 1'b0;
    opdata1    = 32'd50;
    opdata2    = 32'd7;
    start      = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
    end
    annul = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    check("annul_ready", 64'(ready), 64'(0));
    check("annul_result_kept", result, last_exp);
    watch_no_ready("annul_idle", 40);
    run_div(1'b0, 32'd9, 32'd3, "annul_follow");

    // Reset in the middle of a divide.
    opdata1 = 32'd1000;
    opdata2 = 32'd3;
    start   = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
    end
    resetn = 1'b0;
    start  = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check("midreset_ready", 64'(ready), 64'(0));
    check("midreset_result", result, 64'h0);
    watch_no_ready("midreset_idle", 40);
    run_div(1'b0, 32'd9, 32'd3, "reset_follow");

    // Annul beats a simultaneous start.
    opdata1 = 32'd77;
    opdata2 = 32'd4;
    start   = 1'b1;
    annul   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    annul = 1'b0;
    watch_no_ready("annul_vs_start", 40);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic sd;
      sd = 1'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = $urandom_range(1, 255);
        1:       b = -32'($urandom_range(1, 255));
        2:       b = 32'h0;
        3: begin a = 32'h0; b = $urandom; end
        default: b = $urandom;
      endcase
      run_div(sd, a, b, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
